coproc_tx_serializer: RTL
=========================

Name: coproc_tx_serializer

Overview:
Return path of the UART coprocessor. Accepts WIDTH_DIN-bit result words on the coprocessor's dout/dout_valid interface, buffers them in a small FIFO and splits each word into bytes for the UART transmitter. The transmitter side uses a valid/ready byte handshake. The coprocessor output has no backpressure, so this block buffers words and flags any it must drop.

Parameters:
WIDTH_DIN, 128, result word width in bits; multiple of 8, minimum 8.
FIFO_DEPTH, 4, word FIFO entries; power of two, minimum 2.
MSB_FIRST, 1, 1 = send byte [WIDTH_DIN-1 -: 8] first; 0 = send byte [7:0] first.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  reset, asynchronous, active-high.
din  input  WIDTH_DIN  result word from the coprocessor dout.
din_valid  input  1  one-cycle qualifier for din; no ready is returned.
tx_data  output  8  byte to the UART transmitter.
tx_valid  output  1  tx_data is valid.
tx_ready  input  1  transmitter accepts tx_data this cycle.
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of words in the FIFO, excluding the word being sent.
busy  output  1  high when tx_valid=1 or fifo_count!=0.
overflow  output  1  sticky flag: at least one word was dropped.

Behaviour:
- Reset (async assert, sync release): FIFO empty, fifo_count=0, tx_valid=0, tx_data=0, busy=0, overflow=0, FSM in IDLE, byte index 0. Reset asserted mid-word discards the partial word and all queued words. No further bytes are emitted.
- Byte transfer: a byte is transferred on any edge where tx_valid=1 and tx_ready=1.
- While tx_valid=1 and tx_ready=0, tx_data holds stable and tx_valid stays high. tx_valid is never withdrawn before the transfer.
- All outputs are registered.
- FIFO push: on an edge where din_valid=1, din is written if the FIFO is not full, or if it is full and a pop occurs on the same edge.
- Otherwise the word is dropped and overflow is set to 1. overflow is cleared only by rst.
- Simultaneous push and pop leaves fifo_count unchanged.
- FSM state IDLE: tx_valid=0. If the FIFO is non-empty, pop the head word into the shift register, drive the first byte on tx_data, set tx_valid=1 and go to SEND.
- Latency: with an empty, idle block, din_valid sampled at edge k is pushed at k. The pop occurs at k+1, so tx_valid first reads 1 after edge k+1.
- FSM state SEND, on a transfer of a byte that is not the last: advance to the next byte. It is presented the following cycle with tx_valid held high and no bubble.
- FSM state SEND, on a transfer of the last byte (index WIDTH_DIN/8-1):
  - FIFO non-empty: pop the next word on the same edge and present its first byte immediately. Consecutive words stream with zero idle cycles.
  - FIFO empty: tx_valid=0 and go to IDLE.
- Byte order: MSB_FIRST=1 sends the most significant byte first; MSB_FIRST=0 sends the least significant byte first. Each word produces exactly WIDTH_DIN/8 transfers.
- Wrap-around: FIFO read and write pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
  - full: fifo_count == FIFO_DEPTH.
  - empty: fifo_count == 0.
- tx_ready is ignored while tx_valid=0.

Test Plan:
1. Single word, MSB_FIRST=1, tx_ready tied 1. din=128'h000102030405060708090A0B0C0D0E0F pulsed once -> tx_data = 00,01,...,0F on 16 consecutive transfers. tx_valid rises after the second edge following the pulse. Then tx_valid=0 and busy=0.
2. Backpressure: same word, tx_ready = 1,0,0,1,0,1... -> tx_data holds each byte through ready-low cycles. Exactly 16 transfers occur, in order, with no byte repeated or skipped.
3. Streaming: two words (0x00..0F and 0x10..1F) pulsed on back-to-back cycles with tx_ready=1 -> 32 transfers on 32 consecutive edges, values 00..1F. fifo_count peaks at 1.
4. Overflow: tx_ready=0, six words pulsed back-to-back (depth 4). The first word moves to the shift register and four words are queued. The sixth word is dropped -> fifo_count=4, overflow=1. After release, 80 bytes from words 1-5 are emitted. overflow stays 1.
5. Push at full with pop: FIFO full, din_valid asserted on the same edge the last byte of the current word is accepted -> word accepted, fifo_count stays 4, overflow stays 0.
6. Reset mid-word: rst asserted after 5 of 16 bytes with 2 words queued -> tx_valid, fifo_count and busy fall to 0 immediately. After release, no bytes are emitted until a new din_valid arrives.

Source files
------------

// File: rtl/coproc_tx_serializer.sv
// +----------------------------------------------------------------------------+
// | coproc_tx_serializer: buffers coprocessor result words, emits them as bytes |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module coproc_tx_serializer #(
  parameter int WIDTH_DIN  = 128,
  parameter int FIFO_DEPTH = 4,
  parameter int MSB_FIRST  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH_DIN-1:0]          din,
  input  logic                          din_valid,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          overflow
);

  localparam int NB = WIDTH_DIN / 8;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t               state;
  logic [WIDTH_DIN-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [WIDTH_DIN-1:0] shreg;
  logic [IW-1:0]        idx;

  logic                 xfer;
  logic                 last;
  logic                 empty;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 valid_next;
  logic [CW-1:0]        count_next;
  logic [WIDTH_DIN-1:0] head;

  function automatic logic [7:0] first_byte(input logic [WIDTH_DIN-1:0] v);
    if (MSB_FIRST != 0) return v[WIDTH_DIN-1 -: 8];
    else                return v[7:0];
  endfunction

  // shreg holds only the bytes not yet presented, aligned so first_byte works on it
  function automatic logic [WIDTH_DIN-1:0] drop_byte(input logic [WIDTH_DIN-1:0] v);
    if (MSB_FIRST != 0) return v << 8;
    else                return v >> 8;
  endfunction

  assign xfer  = tx_valid & tx_ready;
  assign last  = (idx == IW'(NB - 1));
  assign empty = (fifo_count == '0);
  assign full  = (fifo_count == CW'(FIFO_DEPTH));
  assign head  = mem[rd_ptr];

  assign pop        = !empty && ((state == IDLE) || (xfer && last));
  assign push       = din_valid && (!full || pop);
  assign count_next = fifo_count + CW'(push) - CW'(pop);
  assign valid_next = (state == IDLE) ? !empty : !(xfer && last && empty);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      shreg      <= '0;
      idx        <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= count_next;
      busy       <= valid_next || (count_next != '0);
      if (din_valid && !push) overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (pop) begin
            shreg    <= drop_byte(head);
            tx_data  <= first_byte(head);
            idx      <= '0;
            tx_valid <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            if (!last) begin
              tx_data <= first_byte(shreg);
              shreg   <= drop_byte(shreg);
              idx     <= idx + IW'(1);
            end else if (pop) begin
              shreg   <= drop_byte(head);
              tx_data <= first_byte(head);
              idx     <= '0;
            end else begin
              tx_valid <= 1'b0;
              idx      <= '0;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
